// File: rtl/shiftregister_duplex.sv
// Full-duplex serial shift engine: one shared shift register receives on sampleEdge
// while the TX bit is relaunched from it on launchEdge, in either bit order.
module shiftregister_duplex #(
    parameter int width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sampleEdge,
    input  logic                     launchEdge,
    input  logic                     lsbFirst,
    input  logic                     parallelLoad,
    input  logic [width-1:0]         parallelDataIn,
    input  logic                     serialDataIn,
    output logic                     serialDataOut,
    output logic [width-1:0]         parallelDataOut,
    output logic [width-1:0]         rxWord,
    output logic                     wordDone,
    output logic [$clog2(width)-1:0] bitCount
);

    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

    logic [width-1:0] mem;
    logic [width-1:0] shifted;
    logic             tx_bit;
    logic             load_bit;

    // The shifted value is also what rxWord captures on the completing sample.
    always_comb begin
        shifted  = lsbFirst ? {serialDataIn, mem[width-1:1]} : {mem[width-2:0], serialDataIn};
        load_bit = lsbFirst ? parallelDataIn[0] : parallelDataIn[width-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem      <= '0;
            tx_bit   <= 1'b0;
            bitCount <= '0;
            rxWord   <= '0;
            wordDone <= 1'b0;
        end else begin
            wordDone <= 1'b0;
            if (parallelLoad) begin
                mem      <= parallelDataIn;
                tx_bit   <= load_bit;
                bitCount <= '0;
            end else if (sampleEdge) begin
                mem <= shifted;
                if (bitCount == LAST_BIT) begin
                    bitCount <= '0;
                    rxWord   <= shifted;
                    wordDone <= 1'b1;
                end else begin
                    bitCount <= bitCount + CW'(1);
                end
            end else if (launchEdge) begin
                tx_bit <= lsbFirst ? mem[0] : mem[width-1];
            end
        end
    end

    assign serialDataOut   = tx_bit;
    assign parallelDataOut = mem;

endmodule

// File: tb/tb_shiftregister_duplex.sv
// Directed bench for shiftregister_duplex: reset, both bit orders, strobe
// collisions and back-to-back words with hand-computed expectations.
module tb_shiftregister_duplex;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sampleEdge = 1'b0;
    logic       launchEdge = 1'b0;
    logic       lsbFirst = 1'b0;
    logic       parallelLoad = 1'b0;
    logic [7:0] parallelDataIn = 8'h00;
    logic       serialDataIn = 1'b0;
    logic       serialDataOut;
    logic [7:0] parallelDataOut;
    logic [7:0] rxWord;
    logic       wordDone;
    logic [2:0] bitCount;

    int compared = 0;
    int mismatched = 0;

    shiftregister_duplex #(.width(8)) dut (
        .clk(clk),
        .reset(reset),
        .sampleEdge(sampleEdge),
        .launchEdge(launchEdge),
        .lsbFirst(lsbFirst),
        .parallelLoad(parallelLoad),
        .parallelDataIn(parallelDataIn),
        .serialDataIn(serialDataIn),
        .serialDataOut(serialDataOut),
        .parallelDataOut(parallelDataOut),
        .rxWord(rxWord),
        .wordDone(wordDone),
        .bitCount(bitCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] din, input logic samp,
                                 input logic lau, input logic sin);
        @(negedge clk);
        parallelLoad   = ld;
        parallelDataIn = din;
        sampleEdge     = samp;
        launchEdge     = lau;
        serialDataIn   = sin;
        @(posedge clk);
        #1;
        parallelLoad = 1'b0;
        sampleEdge   = 1'b0;
        launchEdge   = 1'b0;
    endtask

    initial begin
        logic [7:0]  rxPattern;
        logic [7:0]  txPattern;
        logic [15:0] rxStream;
        logic [15:0] txStream;
        int          pulses;

        // Reset state
        #12;
        checkOutput("reset_sdo", 32'(serialDataOut), 32'h0);
        checkOutput("reset_pdo", 32'(parallelDataOut), 32'h0);
        checkOutput("reset_rxword", 32'(rxWord), 32'h0);
        checkOutput("reset_worddone", 32'(wordDone), 32'h0);
        checkOutput("reset_bitcount", 32'(bitCount), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-word
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("midword_bitcount", 32'(bitCount), 32'h3);
        checkOutput("midword_pdo", 32'(parallelDataOut), 32'hF8);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_sdo", 32'(serialDataOut), 32'h0);
        checkOutput("async_pdo", 32'(parallelDataOut), 32'h0);
        checkOutput("async_bitcount", 32'(bitCount), 32'h0);
        checkOutput("async_worddone", 32'(wordDone), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_bitcount", 32'(bitCount), 32'h0);
        checkOutput("post_reset_worddone", 32'(wordDone), 32'h0);

        // MSB-first transfer
        lsbFirst  = 1'b0;
        rxPattern = 8'h3C;
        txPattern = 8'hC1;
        pulses    = 0;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        checkOutput("msb_tx_first", 32'(serialDataOut), 32'(txPattern[7]));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, rxPattern[7-i]);
            if (wordDone) pulses++;
            checkOutput("msb_worddone", 32'(wordDone), (i == 7) ? 32'h1 : 32'h0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (wordDone) pulses++;
            if (i < 7) checkOutput("msb_tx_bit", 32'(serialDataOut), 32'(txPattern[6-i]));
        end
        checkOutput("msb_rxword", 32'(rxWord), 32'h3C);
        checkOutput("msb_pulses", 32'(pulses), 32'h1);
        checkOutput("msb_bitcount", 32'(bitCount), 32'h0);

        // Collisions: load beats sample, sample beats launch
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        checkOutput("load_vs_sample_pdo", 32'(parallelDataOut), 32'h5A);
        checkOutput("load_vs_sample_bitcount", 32'(bitCount), 32'h0);
        checkOutput("load_vs_sample_sdo", 32'(serialDataOut), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        checkOutput("sample_vs_launch_pdo", 32'(parallelDataOut), 32'hB5);
        checkOutput("sample_vs_launch_sdo", 32'(serialDataOut), 32'h0);
        checkOutput("sample_vs_launch_bitcount", 32'(bitCount), 32'h1);

        // Back-to-back words after a single load
        rxStream = 16'h3C96;
        txStream = 16'hC13C;
        pulses   = 0;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, rxStream[15-i]);
            if (wordDone) pulses++;
            if (i == 7) checkOutput("b2b_rxword_first", 32'(rxWord), 32'h3C);
            if (i == 15) checkOutput("b2b_rxword_second", 32'(rxWord), 32'h96);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (wordDone) pulses++;
            if (i < 15) checkOutput("b2b_tx_bit", 32'(serialDataOut), 32'(txStream[14-i]));
        end
        checkOutput("b2b_pulses", 32'(pulses), 32'h2);

        // LSB-first transfer
        lsbFirst  = 1'b1;
        rxPattern = 8'h3C;
        txPattern = 8'hC1;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        checkOutput("lsb_tx_first", 32'(serialDataOut), 32'(txPattern[0]));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, rxPattern[i]);
            checkOutput("lsb_worddone", 32'(wordDone), (i == 7) ? 32'h1 : 32'h0);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (i < 7) checkOutput("lsb_tx_bit", 32'(serialDataOut), 32'(txPattern[i+1]));
        end
        checkOutput("lsb_rxword", 32'(rxWord), 32'h3C);
        checkOutput("lsb_pdo", 32'(parallelDataOut), 32'h3C);
        checkOutput("lsb_bitcount", 32'(bitCount), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
